// File: rtl/alu_src_arbiter.sv
// alu_src_arbiter
//   Arbitrates eight WIDTH-bit sources (A=0 .. H=7) onto one registered
//   output word with valid/ready handshaking. A source is granted by
//   capturing its data into out_data. The granted source sees a one-cycle
//   ack pulse, and sel reports its index to the downstream 8-to-1 mux.
//   The arbitration is round-robin by default.
//   Define ALU_SRC_ARBITER_FIXED_PRI_EN to build fixed priority instead.
//   In that build the lowest eligible index wins and there is no rotating
//   pointer.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   req[7:0]   in   request per source
//   din        in   8*WIDTH source data, source i at din[i*WIDTH +: WIDTH]
//   ack[7:0]   out  one-hot one-cycle pulse, source i captured
//   sel[2:0]   out  index of the last captured source
//   out_valid  out  out_data holds an unconsumed word
//   out_data   out  captured word
//   out_ready  in   consumer accepts out_data this cycle

module alu_src_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] din,
  output logic [7:0]         ack,
  output logic [2:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         ack_r, ack_s;
  logic [2:0]         sel_r, sel_s;
  logic [WIDTH-1:0]   data_r, data_s;
  logic [7:0]         elig_s;
  logic [2:0]         base_s;
  logic [2:0]         scan_idx_s;
  logic [2:0]         win_s;
  logic               found_s;
  logic               capture_s;
  logic [WIDTH-1:0]   src_s [8];

  // Split the flat data bus into one slice per source.
  for (genvar g = 0; g < 8; g++) begin : g_src
    assign src_s[g] = din[g*WIDTH +: WIDTH];
  end

  // A source whose ack is high this cycle cannot be granted again.
  // This keeps a held request from being captured twice.
  assign elig_s = req & ~ack_r;

`ifdef ALU_SRC_ARBITER_FIXED_PRI_EN
  // The scan always starts at source A, so the lowest index wins.
  assign base_s = 3'd0;
`else
  logic [2:0] ptr_r, ptr_s;

  assign base_s = ptr_r;

  // The pointer moves past the winner only when a capture happens.
  always_comb begin
    ptr_s = ptr_r;
    if (capture_s) begin
      ptr_s = win_s + 3'd1;
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 3'd0;
    end else begin
      ptr_r <= ptr_s;
    end
  end
`endif

  // Find the first eligible source, scanning upward from base_s.
  // The 3-bit index add wraps from 7 back to 0.
  always_comb begin
    found_s    = 1'b0;
    win_s      = 3'd0;
    scan_idx_s = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx_s = base_s + k[2:0];
      if (!found_s && elig_s[scan_idx_s]) begin
        found_s = 1'b1;
        win_s   = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // A new word may enter when the slot is empty or is being drained now.
  assign capture_s = found_s && ((state_r == EMPTY) || out_ready);

  // FSM next state and the captured-word / ack datapath.
  always_comb begin
    state_s = state_r;
    ack_s   = 8'd0;
    sel_s   = sel_r;
    data_s  = data_r;
    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (capture_s) begin
          state_s = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
    if (capture_s) begin
      ack_s  = 8'd1 << win_s;
      sel_s  = win_s;
      data_s = src_s[win_s];
    end else begin
      ack_s  = 8'd0;
    end
  end

  // FSM state register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      ack_r   <= 8'd0;
      sel_r   <= 3'd0;
      data_r  <= '0;
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      sel_r   <= sel_s;
      data_r  <= data_s;
    end
  end

  assign ack       = ack_r;
  assign sel       = sel_r;
  assign out_data  = data_r;
  assign out_valid = (state_r == FULL);

endmodule

// File: tb/tb_alu_src_arbiter.sv
module tb_alu_src_arbiter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [7:0]     ack;
  logic [2:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  alu_src_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [2:0]   s;
    logic [W-1:0] d;
    logic [7:0]   a;
  } exp_t;

  exp_t q[$];

  int errs = 0;
  int checks = 0;

  // Behavioural reference state.
  logic         m_valid;
  logic [2:0]   m_sel;
  logic [W-1:0] m_data;
  logic [7:0]   m_ack;
  int           m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 3'd0;
    m_data  = '0;
    m_ack   = 8'd0;
    m_ptr   = 0;
    q.delete();
  endtask

  // Predict the next cycle, push it, clock once, pop it, and compare.
  task automatic step(input string tag);
    exp_t       e;
    logic [7:0] elig;
    int         w;
    bit         can;
    elig = req & ~m_ack;
    can  = !m_valid || out_ready;
    w    = -1;
`ifdef ALU_SRC_ARBITER_FIXED_PRI_EN
    for (int i = 0; i < 8; i++) if (w < 0 && elig[i]) w = i;
`else
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (m_ptr + k) % 8;
      if (w < 0 && elig[i]) w = i;
    end
`endif
    if (can && w >= 0) begin
      m_valid = 1'b1;
      m_sel   = w[2:0];
      m_data  = din[w*W +: W];
      m_ack   = 8'd1 << w;
      m_ptr   = (w + 1) % 8;
    end else if (can) begin
      m_valid = 1'b0;
      m_ack   = 8'd0;
    end else begin
      m_ack   = 8'd0;
    end
    e.v = m_valid; e.s = m_sel; e.d = m_data; e.a = m_ack;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
    chk({tag, ".ack"},   {24'd0, ack},       {24'd0, e.a});
    if (e.v) begin
      chk({tag, ".sel"},  {29'd0, sel}, {29'd0, e.s});
      chk({tag, ".data"}, out_data,     e.d);
    end else begin
      chk({tag, ".idle"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  // Assert reset mid-cycle, check that outputs clear at once, hold reset
  // across one edge, then release.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data",  out_data,           32'd0);
    chk("rst.sel",   {29'd0, sel},       32'd0);
    chk("rst.ack",   {24'd0, ack},       32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst.hold_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.hold_ack",   {24'd0, ack},       32'd0);
    rst = 1'b0;
  endtask

  logic [7:0] prev_ack;

  initial begin
    rst       = 1'b1;
    req       = 8'd0;
    out_ready = 1'b1;
    din       = '0;
    model_reset();
    #1;
    do_reset();

    // A single request from source A.
    din[0*W +: W] = 32'h0000_0045;
    req = 8'h01;
    step("a_only");
    chk("a_only.k_data", out_data, 32'h0000_0045);
    chk("a_only.k_sel",  {29'd0, sel}, 32'd0);
    chk("a_only.k_ack",  {24'd0, ack}, 32'h01);
    req = 8'h00;
    step("a_drain");

    // All eight sources request; the grant order rotates and wraps.
    do_reset();
    din = {32'h00CF_0002, 32'h00F0_0002, 32'h0000_0002, 32'hAACD_FF23,
           32'h0000_0002, 32'h00C4_5008, 32'hAB00_0002, 32'h0000_0045};
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step("rr");
`ifndef ALU_SRC_ARBITER_FIXED_PRI_EN
      chk("rr.k_sel", {29'd0, sel}, k % 8);
`endif
    end
    req = 8'h00;
    step("rr_drain");

    // Back-pressure: the held word stays stable while out_ready is low.
    do_reset();
    req = 8'h10;
    step("bp_cap");
    chk("bp_cap.k_data", out_data, 32'hAACD_FF23);
    req = 8'h80;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("bp_hold");
      chk("bp_hold.k_sel",  {29'd0, sel}, 32'd4);
      chk("bp_hold.k_data", out_data, 32'hAACD_FF23);
      chk("bp_hold.k_ack",  {24'd0, ack}, 32'd0);
    end
    out_ready = 1'b1;
    step("bp_rel");
    chk("bp_rel.k_data", out_data, 32'h00CF_0002);
    chk("bp_rel.k_sel",  {29'd0, sel}, 32'd7);
    req = 8'h00;
    step("bp_drain");

    // Capture C to move the pointer to 3, then request C and F together.
    req = 8'h04;
    step("p3_cap");
    req = 8'h00;
    step("p3_drain");
    req = 8'h24;
    step("cf_first");
`ifdef ALU_SRC_ARBITER_FIXED_PRI_EN
    chk("cf_first.k_sel", {29'd0, sel}, 32'd2);
`else
    chk("cf_first.k_sel", {29'd0, sel}, 32'd5);
`endif
    req = req & ~ack;
    step("cf_second");
`ifdef ALU_SRC_ARBITER_FIXED_PRI_EN
    chk("cf_second.k_sel", {29'd0, sel}, 32'd5);
`else
    chk("cf_second.k_sel", {29'd0, sel}, 32'd2);
`endif
    req = 8'h00;
    step("cf_drain");

    // Reset while a word is held; the held word is discarded.
    req = 8'h01;
    out_ready = 1'b0;
    step("mid_fill");
    req = 8'h80;
    do_reset();
    out_ready = 1'b1;
    step("mid_after");
    chk("mid_after.k_sel", {29'd0, sel}, 32'd7);
    chk("mid_after.k_ack", {24'd0, ack}, 32'h80);
    req = 8'h00;
    step("mid_drain");

    // A lone requester holding req high is granted every other cycle.
    req = 8'h10;
    prev_ack = 8'd0;
    for (int k = 0; k < 8; k++) begin
      step("solo");
      chk("solo.k_ack", {24'd0, ack}, (k % 2 == 0) ? 32'h10 : 32'h00);
      chk("solo.no_b2b", {24'd0, prev_ack & ack}, 32'd0);
      prev_ack = ack;
    end
    req = 8'h00;
    step("solo_drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
